// File: rtl/mic_sample_capture.sv
// SPI-style ADC capture: a periodic tick starts a 16-clock conversion and the 12-bit result is latched.
// Optional MIC_AVG4_EN: wave_sample becomes the mean of the last four samples instead of sample[11:2].
module mic_sample_capture #(
  parameter int CLK_DIV    = 50,
  parameter int SAMPLE_DIV = 5000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        J_MIC_Pin3,
  output logic        J_MIC_Pin1,
  output logic        J_MIC_Pin4,
  output logic [11:0] sample,
  output logic [9:0]  wave_sample,
  output logic        sample_valid,
  output logic        overrun
);

  localparam int TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_e;

  state_e        state_q;
  logic [TW-1:0] tickCnt_q;
  logic [DW-1:0] divCnt_q;
  logic [4:0]    bitCnt_q;
  logic [11:0]   shift_q;
  logic          cs_q, sclk_q, valid_q, overrun_q;
  logic [11:0]   sample_q;
  logic [9:0]    wave_q;
  logic [9:0]    wave_d;
  logic          tick, halfDone, capture;
  logic [11:0]   newSample;

  assign tick      = (tickCnt_q == TICK_LAST);
  assign halfDone  = (divCnt_q == DIV_LAST);
  assign capture   = (state_q == SHIFT) && halfDone && sclk_q && (bitCnt_q == 5'd16);
  assign newSample = shift_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickCnt_q <= '0;
    end else if (tick) begin
      tickCnt_q <= '0;
    end else begin
      tickCnt_q <= tickCnt_q + 1'b1;
    end
  end

`ifdef MIC_AVG4_EN
  logic [11:0] hist0_q, hist1_q, hist2_q;
  logic [13:0] sum;

  assign sum    = 14'(newSample) + 14'(hist0_q) + 14'(hist1_q) + 14'(hist2_q);
  assign wave_d = 10'(sum >> 4);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hist0_q <= '0;
      hist1_q <= '0;
      hist2_q <= '0;
    end else if (capture) begin
      hist0_q <= newSample;
      hist1_q <= hist0_q;
      hist2_q <= hist1_q;
    end
  end
`else
  assign wave_d = newSample[11:2];
`endif

  // Only the low 12 bits of the 16-bit frame are kept; the ADC's leading zeros fall off the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      divCnt_q  <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      sample_q  <= '0;
      wave_q    <= '0;
    end else begin
      valid_q <= 1'b0;
      if (tick && state_q != IDLE) begin
        overrun_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q  <= SETUP;
            cs_q     <= 1'b0;
            divCnt_q <= '0;
          end
        end
        SETUP: begin
          if (halfDone) begin
            state_q  <= SHIFT;
            divCnt_q <= '0;
            bitCnt_q <= '0;
            sclk_q   <= 1'b0;
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end
        SHIFT: begin
          if (halfDone) begin
            divCnt_q <= '0;
            if (!sclk_q) begin
              sclk_q   <= 1'b1;
              shift_q  <= {shift_q[10:0], J_MIC_Pin3};
              bitCnt_q <= bitCnt_q + 1'b1;
            end else if (capture) begin
              state_q  <= DONE;
              cs_q     <= 1'b1;
              sample_q <= newSample;
              wave_q   <= wave_d;
              valid_q  <= 1'b1;
            end else begin
              sclk_q <= 1'b0;
            end
          end else begin
            divCnt_q <= divCnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cs_q    <= 1'b1;
          sclk_q  <= 1'b1;
        end
      endcase
    end
  end

  assign J_MIC_Pin1   = cs_q;
  assign J_MIC_Pin4   = sclk_q;
  assign sample       = sample_q;
  assign wave_sample  = wave_q;
  assign sample_valid = valid_q;
  assign overrun      = overrun_q;

endmodule

// File: doc/mic_sample_capture.md
MIC_SAMPLE_CAPTURE -- requirements
Module: mic_sample_capture

Interface
REQ-001 Parameter CLK_DIV, default 50: clk cycles per SCLK half-period (1 MHz SCLK at 100 MHz clk).
REQ-002 Parameter SAMPLE_DIV, default 5000: clk cycles per conversion start (20 kHz at 100 MHz clk).
REQ-003 clk  in  1  system clock, 100 MHz; all logic on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 J_MIC_Pin3  in  1  ADC serial data (MISO).
REQ-006 J_MIC_Pin1  out  1  ADC chip select, active low.
REQ-007 J_MIC_Pin4  out  1  ADC serial clock (SCLK).
REQ-008 sample  out  12  last completed 12-bit conversion.
REQ-009 wave_sample  out  10  display sample for the waveform store, sample[11:2].
REQ-010 sample_valid  out  1  one-cycle pulse when sample/wave_sample update.
REQ-011 overrun  out  1  sticky flag: a conversion start was dropped.

Function
REQ-012 Free-running tick counter SHALL count 0..SAMPLE_DIV-1 and wrap; tick = counter at SAMPLE_DIV-1, exactly every SAMPLE_DIV cycles.
REQ-013 FSM states: IDLE, SETUP, SHIFT, DONE.
REQ-014 IDLE: J_MIC_Pin1=1, J_MIC_Pin4=1; on tick go to SETUP and drive J_MIC_Pin1=0 from the next cycle.
REQ-015 SETUP SHALL last CLK_DIV cycles, J_MIC_Pin4=1, then go to SHIFT.
REQ-016 SHIFT SHALL generate 16 SCLK periods: J_MIC_Pin4=0 for CLK_DIV cycles then 1 for CLK_DIV cycles; total 32*CLK_DIV cycles.
REQ-017 J_MIC_Pin3 SHALL be shifted MSB-first into a 16-bit register on the clk edge at which J_MIC_Pin4 goes 0->1.
REQ-018 After the 16th rising SCLK edge, go to DONE for exactly one cycle: J_MIC_Pin1=1, sample=shift[11:0], sample_valid=1; then IDLE.
REQ-019 J_MIC_Pin1 SHALL be low for exactly 33*CLK_DIV cycles per conversion; sample_valid rises 33*CLK_DIV cycles after J_MIC_Pin1 falls.
REQ-020 Upper 4 received bits (ADC leading zeros) SHALL be discarded, not checked.
REQ-021 wave_sample SHALL update in the same cycle as sample; sample/wave_sample hold between updates.
REQ-022 Tick arriving while state != IDLE SHALL be dropped (no restart, no queueing) and SHALL set overrun=1 until reset.
REQ-023 Legal configuration: SAMPLE_DIV >= 33*CLK_DIV+2, CLK_DIV >= 1; overrun never sets under legal configuration.

Reset
REQ-024 rst_n=0 SHALL immediately force: state IDLE, J_MIC_Pin1=1, J_MIC_Pin4=1, sample=0, wave_sample=0, sample_valid=0, overrun=0, all counters and shift register 0.
REQ-025 Reset during SETUP/SHIFT SHALL abort the conversion with no sample_valid; first tick after release occurs SAMPLE_DIV cycles after rst_n rises.

Configuration
REQ-026 Macro MIC_AVG4_EN defined: wave_sample = (sum of last 4 completed samples)>>4 (12-bit mean, then [11:2]), history cleared by reset, zeros fill unfilled slots; sample unaffected.
REQ-027 Macro MIC_AVG4_EN undefined: wave_sample = sample[11:2] per REQ-009, no averaging logic present.

Verification
REQ-028 ADC model returns 16'h0ABC -> sample=12'hABC, wave_sample=10'h2AF, sample_valid one cycle, J_MIC_Pin1 low exactly 1650 cycles.
REQ-029 Defaults, run 3 conversions -> sample_valid pulses exactly 5000 cycles apart, exactly 16 SCLK rising edges per CS-low window, overrun=0.
REQ-030 Assert rst_n=0 at 8th SCLK rise -> outputs at reset values same cycle, no sample_valid; next conversion after release yields correct value.
REQ-031 SAMPLE_DIV=1000, CLK_DIV=50 -> overrun=1 at second tick, each conversion still completes with correct data, no truncated CS window.
REQ-032 MIC_AVG4_EN defined, samples 12'h400,12'h800,12'hC00,12'h000 -> wave_sample after each: 10'h040,10'h0C0,10'h180,10'h180.
REQ-033 ADC model drives 16'hFFFF -> sample=12'hFFF, wave_sample=10'h3FF (upper nibble ignored).
